// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S slave receiver: channel encoding and receiver state.
package i2s_pkg;

  localparam logic I2S_CH_LEFT  = 1'b0;
  localparam logic I2S_CH_RIGHT = 1'b1;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } rx_state_e;

  // Bit-counter width able to hold the saturation value PDATA_WIDTH+1.
  function automatic int cnt_width(input int pdata_width);
    return $clog2(pdata_width + 2);
  endfunction

endpackage

// File: rtl/i2s_slave_rx_if.sv
// Serial line inputs and parallel stereo-frame outputs of the I2S slave receiver.
interface i2s_slave_rx_if #(
  parameter int PDATA_WIDTH = 32
);
  logic                   lrck_in;
  logic                   sclk_in;
  logic                   sdata_in;
  logic [PDATA_WIDTH-1:0] pldata_out;
  logic [PDATA_WIDTH-1:0] prdata_out;
  logic                   pvalid_out;
  logic                   ferr_out;

  modport master (
    output lrck_in, sclk_in, sdata_in,
    input  pldata_out, prdata_out, pvalid_out, ferr_out
  );

  modport slave (
    input  lrck_in, sclk_in, sdata_in,
    output pldata_out, prdata_out, pvalid_out, ferr_out
  );
endinterface

// File: rtl/i2s_sync.sv
// Parameterised-width two-flop synchroniser, asynchronous active-low reset.
module i2s_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: oversamples LRCK/SCLK/SDATA on mclk_in and publishes one stereo frame per LRCK period.
// Define I2S_SLAVE_RX_FERR_EN to flag frames whose words are not exactly PDATA_WIDTH bits long.
module i2s_slave_rx
  import i2s_pkg::*;
#(
  parameter int PDATA_WIDTH = 32
) (
  input logic            mclk_in,
  input logic            arstn_in,
  i2s_slave_rx_if.slave  bus
);
  localparam int CNT_W = cnt_width(PDATA_WIDTH);

  logic [2:0]             sync_q;
  logic                   sclk_d;
  logic                   lrck_s, sclk_s, sdat_s;
  logic                   bit_ev, boundary;
  rx_state_e              state;
  logic                   lrck_prev;
  logic [PDATA_WIDTH-1:0] wreg, wnext, stage;
  logic [CNT_W-1:0]       cnt, cnt_inc;
  logic [PDATA_WIDTH-1:0] pldata, prdata;
  logic                   pvalid;

  i2s_sync #(.WIDTH(3)) u_sync (
    .clk   (mclk_in),
    .rst_n (arstn_in),
    .d     ({bus.lrck_in, bus.sclk_in, bus.sdata_in}),
    .q     (sync_q)
  );

  assign {lrck_s, sclk_s, sdat_s} = sync_q;
  assign bit_ev   = sclk_s & ~sclk_d;
  assign boundary = bit_ev && (lrck_s != lrck_prev);

  // Word with the current bit placed MSB-first; bits past PDATA_WIDTH fall off.
  always_comb begin
    wnext = wreg;
    for (int i = 0; i < PDATA_WIDTH; i++)
      if (cnt == CNT_W'(PDATA_WIDTH - 1 - i)) wnext[i] = sdat_s;
    cnt_inc = (cnt == CNT_W'(PDATA_WIDTH + 1)) ? cnt : cnt + CNT_W'(1);
  end

`ifdef I2S_SLAVE_RX_FERR_EN
  logic err_flag, ferr;
  logic word_bad;
  assign word_bad = (cnt_inc != CNT_W'(PDATA_WIDTH));
`endif

  always_ff @(posedge mclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      sclk_d    <= 1'b0;
      state     <= ST_SYNC;
      lrck_prev <= 1'b1;
      wreg      <= '0;
      cnt       <= '0;
      stage     <= '0;
      pldata    <= '0;
      prdata    <= '0;
      pvalid    <= 1'b0;
`ifdef I2S_SLAVE_RX_FERR_EN
      err_flag  <= 1'b0;
      ferr      <= 1'b0;
`endif
    end else begin
      sclk_d <= sclk_s;
      pvalid <= 1'b0;
`ifdef I2S_SLAVE_RX_FERR_EN
      ferr   <= 1'b0;
`endif
      if (bit_ev) begin
        lrck_prev <= lrck_s;
        if (boundary) begin
          wreg <= '0;
          cnt  <= '0;
          case (state)
            // Wait for a right-to-left edge so the first frame starts cleanly aligned.
            ST_SYNC: if (lrck_s == I2S_CH_LEFT) state <= ST_RUN;
            ST_RUN: begin
              if (lrck_s == I2S_CH_RIGHT) begin
                stage <= wnext;
`ifdef I2S_SLAVE_RX_FERR_EN
                err_flag <= word_bad;
`endif
              end else begin
                pldata <= stage;
                prdata <= wnext;
                pvalid <= 1'b1;
`ifdef I2S_SLAVE_RX_FERR_EN
                ferr     <= err_flag | word_bad;
                err_flag <= 1'b0;
`endif
              end
            end
            default: state <= ST_SYNC;
          endcase
        end else begin
          wreg <= wnext;
          cnt  <= cnt_inc;
        end
      end
    end
  end

  assign bus.pldata_out = pldata;
  assign bus.prdata_out = prdata;
  assign bus.pvalid_out = pvalid;
`ifdef I2S_SLAVE_RX_FERR_EN
  assign bus.ferr_out   = ferr;
`else
  assign bus.ferr_out   = 1'b0;
`endif
endmodule

// File: tb/tb_i2s_slave_rx.sv
// Bench for i2s_slave_rx: table-driven frames, reset mid-word, and jittered random frames against a bit-queue model.
module tb_i2s_slave_rx;
  localparam int W = 32;
`ifdef I2S_SLAVE_RX_FERR_EN
  localparam logic FERR = 1'b1;
`else
  localparam logic FERR = 1'b0;
`endif

  typedef struct {
    logic [63:0] lb; int nl;
    logic [63:0] rb; int nr;
    int          half;
    logic [31:0] el, er;
    logic        ee;
  } vec_t;

  typedef struct {
    logic [31:0] l, r;
    logic        e;
  } frame_t;

  logic mclk, arstn;
  i2s_slave_rx_if #(.PDATA_WIDTH(W)) bus ();
  i2s_slave_rx #(.PDATA_WIDTH(W)) dut (.mclk_in(mclk), .arstn_in(arstn), .bus(bus));

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int total = 0, bad = 0;
  int cyc = 0, last_rise = -100, pv_cnt = 0;
  logic prev_pv = 1'b0, last_ferr = 1'b0, lat_chk = 1'b1, rnd = 1'b0;
  int lo = 2, hi = 2, ratio = 4;
  logic pending = 1'b0;
  frame_t sb[$];

  // Reference model: collect the bits of the current half-frame; finish at every LRCK change.
  logic mq[$];
  logic m_prev, m_run, m_stg_err;
  logic [31:0] m_stg;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete(); sb.delete();
    m_prev = 1'b1; m_run = 1'b0; m_stg = '0; m_stg_err = 1'b0;
  endtask

  task automatic model_bit(input logic v, input logic d);
    logic [31:0] word;
    logic err;
    if (v != m_prev) begin
      mq.push_back(d);
      word = '0;
      for (int i = 0; i < W; i++) if (i < mq.size()) word[W-1-i] = mq[i];
      err = (mq.size() != W);
      if (m_run) begin
        if (v) begin m_stg = word; m_stg_err = err; end
        else begin
          sb.push_back('{m_stg, word, FERR & (m_stg_err | err)});
          m_stg_err = 1'b0;
        end
      end else if (!v) m_run = 1'b1;
      mq.delete();
    end else mq.push_back(d);
    m_prev = v;
  endtask

  function automatic int jit(input int base);
    int t;
    t = base + int'($urandom_range(0, 8)) - 4;
    return (t < 22) ? 22 : t;
  endfunction

  task automatic slot(input logic v, input logic d);
    if (rnd) begin
      bus.sclk_in = 1'b0; bus.lrck_in = v; bus.sdata_in = d;
      #(jit(ratio * 5));
      bus.sclk_in = 1'b1;
      model_bit(v, d);
      #(jit(ratio * 5));
    end else begin
      @(negedge mclk); #1;
      bus.sclk_in = 1'b0; bus.lrck_in = v; bus.sdata_in = d;
      repeat (lo) @(negedge mclk);
      #1 bus.sclk_in = 1'b1;
      last_rise = cyc;
      model_bit(v, d);
      repeat (hi - 1) @(negedge mclk);
    end
  endtask

  // Remaining bits of a word after its boundary slot; the last bit is carried into the next boundary slot.
  task automatic body(input logic v, input logic [63:0] bits, input int n);
    for (int j = 0; j < n - 1; j++) slot(v, bits[63-j]);
    pending = bits[64-n];
  endtask

  always @(negedge mclk) begin
    cyc++;
    if (bus.pvalid_out) begin
      frame_t e;
      pv_cnt++;
      last_ferr = bus.ferr_out;
      chk("pv_width", {63'd0, prev_pv}, 64'd0);
      if (lat_chk) chk("latency", 64'(cyc), 64'(last_rise + 3));
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: got pvalid want none");
      end else begin
        e = sb.pop_front();
        chk("sb_l", 64'(bus.pldata_out), 64'(e.l));
        chk("sb_r", 64'(bus.prdata_out), 64'(e.r));
        chk("sb_err", 64'(bus.ferr_out), 64'(e.e));
      end
    end else if (bus.ferr_out) chk("ferr_alone", 64'(bus.ferr_out), 64'd0);
    prev_pv = bus.pvalid_out;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: got no finish want finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1);
  end

  vec_t tv[8];
  int pv_base;

  initial begin
    tv[0] = '{{32'h12345678, 32'h0}, 32, {32'h9ABCDEF0, 32'h0}, 32, 2, 32'h12345678, 32'h9ABCDEF0, 1'b0};
    tv[1] = '{{32'hFFFFFFFF, 32'h0}, 32, {32'h00000000, 32'h0}, 32, 2, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    tv[2] = '{{32'h00000000, 32'h0}, 32, {32'hFFFFFFFF, 32'h0}, 32, 3, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    tv[3] = '{{24'hABCDEF, 40'h0}, 24, {24'h123456, 40'h0}, 24, 2, 32'hABCDEF00, 32'h12345600, FERR};
    tv[4] = '{{32'hCAFEF00D, 8'hFF, 24'h0}, 40, {32'h0F0F0F0F, 32'h0}, 32, 2, 32'hCAFEF00D, 32'h0F0F0F0F, FERR};
    tv[5] = '{{32'h00000001, 32'h0}, 32, {32'h80000000, 32'h0}, 32, 4, 32'h00000001, 32'h80000000, 1'b0};
    tv[6] = '{{32'hA5A5A5A5, 1'b1, 31'h0}, 33, {32'h5A5A5A5A, 32'h0}, 32, 2, 32'hA5A5A5A5, 32'h5A5A5A5A, FERR};
    tv[7] = '{{1'b1, 63'h0}, 1, {32'h13579BDF, 32'h0}, 32, 2, 32'h80000000, 32'h13579BDF, FERR};

    arstn = 1'b0;
    bus.lrck_in = 1'b1; bus.sclk_in = 1'b0; bus.sdata_in = 1'b0;
    model_reset();
    repeat (3) @(negedge mclk);
    chk("rst_l", 64'(bus.pldata_out), 64'd0);
    chk("rst_r", 64'(bus.prdata_out), 64'd0);
    chk("rst_pv", 64'(bus.pvalid_out), 64'd0);
    chk("rst_ferr", 64'(bus.ferr_out), 64'd0);
    #1 arstn = 1'b1;

    // Tail of a right word seen in SYNC; the following right-to-left edge aligns the receiver.
    slot(1'b1, 1'b0);
    body(1'b1, {32'hDEADBEEF, 32'h0}, 12);
    slot(1'b0, pending);
    pv_base = pv_cnt;
    chk("sync_no_pv", 64'(pv_cnt), 64'd0);

    for (int i = 0; i < 8; i++) begin
      lo = tv[i].half; hi = tv[i].half;
      body(1'b0, tv[i].lb, tv[i].nl);
      slot(1'b1, pending);
      body(1'b1, tv[i].rb, tv[i].nr);
      slot(1'b0, pending);
      repeat (3) @(negedge mclk);
      #1;
      chk("tbl_l", 64'(bus.pldata_out), 64'(tv[i].el));
      chk("tbl_r", 64'(bus.prdata_out), 64'(tv[i].er));
      chk("tbl_err", 64'(last_ferr), 64'(tv[i].ee));
      chk("tbl_pvcnt", 64'(pv_cnt), 64'(pv_base + i + 1));
    end

    // Reset in the middle of a left word, during the SCLK low phase.
    lo = 2; hi = 2;
    for (int j = 0; j < 10; j++) slot(1'b0, 1'($urandom_range(0, 1)));
    @(negedge mclk); #1;
    bus.sclk_in = 1'b0;
    arstn = 1'b0;
    #1;
    chk("mid_rst_l", 64'(bus.pldata_out), 64'd0);
    chk("mid_rst_r", 64'(bus.prdata_out), 64'd0);
    chk("mid_rst_pv", 64'(bus.pvalid_out), 64'd0);
    model_reset();
    pv_base = pv_cnt;
    repeat (2) @(negedge mclk);
    #1 arstn = 1'b1;
    body(1'b0, {$urandom, $urandom}, 22);
    slot(1'b1, pending);
    body(1'b1, {32'h2468ACE0, 32'h0}, 32);
    chk("rst_no_early_pv", 64'(pv_cnt), 64'(pv_base));
    slot(1'b0, pending);
    for (int f = 0; f < 2; f++) begin
      body(1'b0, {$urandom, 32'h0}, 32);
      slot(1'b1, pending);
      body(1'b1, {$urandom, 32'h0}, 32);
      slot(1'b0, pending);
    end
    repeat (4) @(negedge mclk);
    chk("rst_pvcnt", 64'(pv_cnt), 64'(pv_base + 3));

    // Free-running SCLK with random ratio, phase and jitter.
    repeat (2) @(negedge mclk);
    lat_chk = 1'b0;
    rnd = 1'b1;
    #($urandom_range(0, 9));
    for (int f = 0; f < 50; f++) begin
      int nl, nr;
      ratio = int'($urandom_range(4, 16));
      nl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 40)) : 32;
      nr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 40)) : 32;
      body(1'b0, {$urandom, $urandom}, nl);
      slot(1'b1, pending);
      body(1'b1, {$urandom, $urandom}, nr);
      slot(1'b0, pending);
    end
    repeat (6) @(negedge mclk);
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
